// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared encodings and sizing
// helpers for the FIFO request scheduler.
package fifo_ctrl_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE_WR = 2'd1;
  localparam logic [1:0] ISSUE_RD = 2'd2;
  localparam logic [1:0] SETTLE   = 2'd3;

  localparam logic FILL  = 1'b0;
  localparam logic DRAIN = 1'b1;

  function automatic int unsigned clog2(
    input int unsigned v
  );
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  function automatic int unsigned bits1(
    input int unsigned v
  );
    int unsigned r;
    r = clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int unsigned cnt_w_for(
    input int unsigned depth
  );
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_req_scheduler_btn_edge_sync.sv
// btn_edge_sync: 2-flop synchronizer, optional
// debounce (DEBOUNCE_EN) and rising-edge pulse.
module btn_edge_sync
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_i,
  output logic pulse_o
);

  logic s1_q;
  logic s2_q;
  logic lvl;
  logic prev_q;

  if (DEB_CYCLES == 0) begin : g_bad_deb
    $error("DEB_CYCLES must be nonzero");
  end

  // Bring the raw button into the clock domain.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DW = bits1(DEB_CYCLES);

  logic [DW-1:0] cnt_q;
  logic          deb_q;

  // Follow the input only after it held steady.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (s2_q == deb_q) begin
      cnt_q <= '0;
    end else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
      cnt_q <= '0;
      deb_q <= s2_q;
    end else begin
      cnt_q <= cnt_q + DW'(1);
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = s2_q;
`endif

  // Remember last level for edge detection.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) prev_q <= 1'b0;
    else      prev_q <= lvl;
  end

  assign pulse_o = lvl & ~prev_q;

endmodule

// File: rtl/fifo_req_scheduler.sv
// fifo_req_scheduler: arbitrates manual buttons
// and an auto fill/drain sequencer onto a FIFO.
// Optional macro: DEBOUNCE_EN (button debounce).
module fifo_req_scheduler
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned WL         = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_btn,
  input  logic             rd_btn,
  input  logic             auto_btn,
  input  logic [WL-1:0]    sw_data,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             wReq,
  output logic             rReq,
  output logic [WL-1:0]    din,
  output logic             busy,
  output logic             mode_auto,
  output logic [CNT_W-1:0] level,
  output logic             reject
);

  localparam int unsigned TW = bits1(TICK_DIV);

  if (TICK_DIV < 2) begin : g_bad_tick
    $error("TICK_DIV must be at least 2");
  end
  if (CNT_W < cnt_w_for(DEPTH)) begin : g_bad_cnt
    $error("CNT_W too narrow for DEPTH");
  end

  logic wr_p;
  logic rd_p;
  logic au_p;

  btn_edge_sync #(.DEB_CYCLES(DEB_CYCLES)) u_wr (
    .CLK     (CLK),
    .RST     (RST),
    .btn_i   (wr_btn),
    .pulse_o (wr_p)
  );

  btn_edge_sync #(.DEB_CYCLES(DEB_CYCLES)) u_rd (
    .CLK     (CLK),
    .RST     (RST),
    .btn_i   (rd_btn),
    .pulse_o (rd_p)
  );

  btn_edge_sync #(.DEB_CYCLES(DEB_CYCLES)) u_au (
    .CLK     (CLK),
    .RST     (RST),
    .btn_i   (auto_btn),
    .pulse_o (au_p)
  );

  logic [1:0]       st_q,    st_d;
  logic             mode_q,  mode_d;
  logic             ph_q,    ph_d;
  logic [WL-1:0]    din_q,   din_d;
  logic [WL-1:0]    pat_q,   pat_d;
  logic [CNT_W-1:0] lvl_q,   lvl_d;
  logic             tog_q,   tog_d;
  logic             tp_q,    tp_d;
  logic [TW-1:0]    tick_q,  tick_d;
  logic             lwr_q,   lwr_d;
  logic             wreq_q,  wreq_d;
  logic             rreq_q,  rreq_d;
  logic             rej_q,   rej_d;

  logic idle;
  logic tog_now;
  logic tick_hit;
  logic tick_go;
  logic wok;
  logic rok;
  logic take_wr;
  logic take_rd;
  logic auto_wr;

  assign idle     = (st_q == IDLE);
  assign tog_now  = au_p | tog_q;
  assign tick_hit = mode_q &&
                    (tick_q == TW'(TICK_DIV - 1));
  assign tick_go  = tp_q | tick_hit;
  assign wok      = wr_p & ~fifo_full;
  assign rok      = rd_p & ~fifo_empty;

  // Next-state: sequencing, arbitration, level.
  always_comb begin
    st_d    = st_q;
    mode_d  = mode_q;
    ph_d    = ph_q;
    din_d   = din_q;
    pat_d   = pat_q;
    lvl_d   = lvl_q;
    tog_d   = tog_q;
    tp_d    = tp_q;
    tick_d  = tick_q;
    lwr_d   = lwr_q;
    wreq_d  = 1'b0;
    rreq_d  = 1'b0;
    rej_d   = 1'b0;
    take_wr = 1'b0;
    take_rd = 1'b0;
    auto_wr = 1'b0;

    if (wreq_q && lvl_q < CNT_W'(DEPTH))
      lvl_d = lvl_q + CNT_W'(1);
    else if (rreq_q && lvl_q != '0)
      lvl_d = lvl_q - CNT_W'(1);

    if (mode_q) begin
      tick_d = tick_hit ? '0 : tick_q + TW'(1);
      if (tick_hit) tp_d = 1'b1;
    end

    if (au_p) tog_d = 1'b1;

    if ((wr_p | rd_p) &&
        (!idle || mode_q || tog_now))
      rej_d = 1'b1;

    unique case (st_q)
      ISSUE_WR, ISSUE_RD: st_d = SETTLE;
      SETTLE:             st_d = IDLE;
      IDLE: begin
        if (tog_now) begin
          mode_d = ~mode_q;
          tog_d  = 1'b0;
          tick_d = '0;
          tp_d   = 1'b0;
          ph_d   = FILL;
        end else if (mode_q) begin
          if (tick_go) begin
            tp_d = 1'b0;
            if (ph_q == FILL) begin
              if (!fifo_full) begin
                take_wr = 1'b1;
              end else begin
                ph_d    = DRAIN;
                take_rd = ~fifo_empty;
              end
            end else begin
              if (!fifo_empty) begin
                take_rd = 1'b1;
              end else begin
                ph_d    = FILL;
                take_wr = ~fifo_full;
              end
            end
            auto_wr = take_wr;
          end
        end else if (wr_p && rd_p) begin
          rej_d = 1'b1;
          if (!lwr_q) begin
            take_wr = wok;
            take_rd = ~wok & rok;
          end else begin
            take_rd = rok;
            take_wr = ~rok & wok;
          end
          if (take_wr | take_rd)
            lwr_d = take_wr;
        end else begin
          take_wr = wok;
          take_rd = rok;
          if ((wr_p && !wok) || (rd_p && !rok))
            rej_d = 1'b1;
        end
      end
    endcase

    if (take_wr) begin
      st_d   = ISSUE_WR;
      wreq_d = 1'b1;
      din_d  = auto_wr ? pat_q : sw_data;
      if (auto_wr) pat_d = pat_q + WL'(1);
    end
    if (take_rd) begin
      st_d   = ISSUE_RD;
      rreq_d = 1'b1;
    end
  end

  // State registers; strobes clear instantly on reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q   <= IDLE;
      mode_q <= 1'b0;
      ph_q   <= FILL;
      din_q  <= '0;
      pat_q  <= '0;
      lvl_q  <= '0;
      tog_q  <= 1'b0;
      tp_q   <= 1'b0;
      tick_q <= '0;
      lwr_q  <= 1'b0;
      wreq_q <= 1'b0;
      rreq_q <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      mode_q <= mode_d;
      ph_q   <= ph_d;
      din_q  <= din_d;
      pat_q  <= pat_d;
      lvl_q  <= lvl_d;
      tog_q  <= tog_d;
      tp_q   <= tp_d;
      tick_q <= tick_d;
      lwr_q  <= lwr_d;
      wreq_q <= wreq_d;
      rreq_q <= rreq_d;
      rej_q  <= rej_d;
    end
  end

  assign wReq      = wreq_q;
  assign rReq      = rreq_q;
  assign din       = din_q;
  assign busy      = ~idle;
  assign mode_auto = mode_q;
  assign level     = lvl_q;
  assign reject    = rej_q;

endmodule

// File: doc/fifo_req_scheduler.md
Name: fifo_req_scheduler

Overview:
Sequences and arbitrates access to the board-level FIFO (WL-bit, DEPTH-entry) between two requesters: manual push-buttons and an internal auto fill/drain sequencer.
- Converts raw buttons into single-cycle wReq/rReq pulses.
- Gates illegal operations using full/empty.
- Drives FIFO din from switches (manual) or an incrementing pattern (auto).
- Sits between the top-level button/switch inputs and the FIFO instance.

Parameters:
- WL, 8: data word width.
- DEPTH, 4: FIFO depth; sets width of level.
- TICK_DIV, 50_000_000: CLK cycles between auto-mode operations; minimum 2.
- CNT_W, 3: width of level; must hold 0..DEPTH.
- DEB_CYCLES, 1_000_000: debounce stable-time in cycles; used only with DEBOUNCE_EN.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  asynchronous, active-low reset.
- wr_btn  input  1  raw write button, asynchronous.
- rd_btn  input  1  raw read button, asynchronous.
- auto_btn  input  1  raw auto-mode toggle button, asynchronous.
- sw_data  input  WL  switch data for manual writes.
- fifo_full  input  1  FIFO full flag.
- fifo_empty  input  1  FIFO empty flag.
- wReq  output  1  FIFO write strobe, one cycle per operation.
- rReq  output  1  FIFO read strobe, one cycle per operation.
- din  output  WL  FIFO write data; valid in the wReq cycle.
- busy  output  1  high while the FSM is outside IDLE.
- mode_auto  output  1  1 = auto sequencer owns the FIFO.
- level  output  CNT_W  scheduler-tracked occupancy.
- reject  output  1  one-cycle pulse when a request is refused.

Behaviour:
- Reset (RST low, async): wReq=0, rReq=0, din=0, busy=0, mode_auto=0, level=0, reject=0. FSM goes to IDLE. Tick counter, pattern counter and last_served are cleared. Synchronizer flops clear to 0.
- Button path: each button passes through a 2-flop synchronizer, then rising-edge detect, giving a 1-cycle req pulse. A button rising before edge k produces its req pulse in cycle k+2. Holding a button produces exactly one pulse.
- FSM states:
  - IDLE: waits for a request.
  - ISSUE_WR: wReq=1 for one cycle; din is held.
  - ISSUE_RD: rReq=1 for one cycle.
  - SETTLE: one-cycle gap so the FIFO flags update.
  - Every operation is IDLE -> ISSUE_x -> SETTLE -> IDLE: one operation per 3 cycles minimum.
- Manual write (mode_auto=0): a wr req in IDLE with fifo_full=0 latches sw_data into din and goes to ISSUE_WR. With fifo_full=1, reject pulses and the FSM stays in IDLE.
- Manual read: a rd req in IDLE with fifo_empty=0 goes to ISSUE_RD. With fifo_empty=1, reject pulses.
- Simultaneous wr and rd req in the same cycle: round-robin on last_served; after reset the write wins. If the winner is illegal, the other is taken if legal. The loser is dropped and reject pulses.
- Requests arriving while busy=1 are dropped with reject.
- level: +1 on the wReq cycle, -1 on the rReq cycle, saturating at 0 and DEPTH.
- Auto mode:
  - An auto_btn req toggles mode_auto; the toggle is applied only in IDLE, otherwise held pending until IDLE.
  - On entering auto: tick counter cleared, phase=FILL.
  - Every TICK_DIV cycles one op is issued. In FILL: write the pattern counter value, then increment it mod 2^WL. In DRAIN: read.
  - FILL switches to DRAIN when fifo_full=1 at a tick; DRAIN switches to FILL when fifo_empty=1 at a tick. The switching tick issues the opposite op in the same tick.
  - Manual wr/rd reqs in auto mode produce reject only.
- Leaving auto mid-operation: the current ISSUE/SETTLE sequence completes first, then manual mode resumes. level is preserved.
- Reset mid-operation: an in-flight strobe is deasserted immediately (async).

Optional Feature:
- DEBOUNCE_EN defined: each synchronized button must stay stable for DEB_CYCLES cycles before its debounced level changes. The edge detect operates on the debounced level, so req latency becomes 2+DEB_CYCLES cycles.
- DEBOUNCE_EN undefined: no debounce logic; latency 2 cycles; DEB_CYCLES is unused.

Decomposition:
- Package fifo_ctrl_pkg: FSM state encodings (IDLE, ISSUE_WR, ISSUE_RD, SETTLE), phase encodings (FILL, DRAIN), clog2 helper for CNT_W.
- Sub-module btn_edge_sync: synchronizer, optional debounce and rising-edge pulse. Instanced three times, once each for wr, rd and auto.

Test Plan:
- Reset then wr_btn high with sw_data=8'h2A -> single wReq pulse 3 cycles later with din=8'h2A; level=1; busy high for 2 cycles.
- Four writes then a fifth with fifo_full=1 -> fifth produces reject pulse and no wReq; level stays 4.
- fifo_empty=1 and rd_btn -> reject, no rReq. Then wr_btn and rd_btn rising together twice with FIFO half full -> first served write, second served read.
- TICK_DIV=4, auto toggled, FIFO model DEPTH=4 -> din sequence 0,1,2,3 with wReq every 4 cycles, then 4 rReq pulses, then writes resume with din=4.
- Auto toggled while in ISSUE_WR -> strobe completes, mode_auto stays unchanged until IDLE; manual wr during auto -> reject only.
- RST low while ISSUE_RD -> rReq drops without a clock edge; all outputs 0.
